// File: rtl/lectura.sv
// Input-capture front end of the sequential 8x8 multiplier: synchronizes the switch banks and
// push-button, debounces the button and latches both operands with a start pulse on each press.
module lectura #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic        pb_entrada,
    output logic [15:0] LED,
    output logic        LED_reset,
    output logic        LED_pb,
    output logic [7:0]  multiplicador,
    output logic [7:0]  multiplicando,
    output logic        pushbutton_salida
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][7:0] a_sync_q, a_sync_d;
    logic [SYNC_STAGES-1:0][7:0] b_sync_q, b_sync_d;
    logic [SYNC_STAGES-1:0]      pb_sync_q, pb_sync_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        db_q, db_d;
    logic [15:0]                 led_q, led_d;
    logic                        led_reset_q;
    logic [7:0]                  op_a_q, op_a_d;
    logic [7:0]                  op_b_q, op_b_d;
    logic                        pulse_q, pulse_d;

    logic [7:0] a_sync;
    logic [7:0] b_sync;
    logic       pb_sync;
    logic       press;

    assign a_sync  = a_sync_q[SYNC_STAGES-1];
    assign b_sync  = b_sync_q[SYNC_STAGES-1];
    assign pb_sync = pb_sync_q[SYNC_STAGES-1];

    // Next-state logic: synchronizer shift, debounce counter, press detection and operand capture.
    always_comb begin
        a_sync_d  = {a_sync_q[SYNC_STAGES-2:0], A};
        b_sync_d  = {b_sync_q[SYNC_STAGES-2:0], B};
        pb_sync_d = {pb_sync_q[SYNC_STAGES-2:0], pb_entrada};
        led_d     = {b_sync, a_sync};
        cnt_d     = {CNT_W{1'b0}};
        db_d      = db_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;

        // The counter only advances while the synchronized button disagrees with db,
        // so any bounce back to the current level restarts the window.
        if (pb_sync != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = ~db_q;
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = {CNT_W{1'b0}};
        end

        press   = db_d & ~db_q;
        pulse_d = press;
        if (press) begin
            op_a_d = a_sync;
            op_b_d = b_sync;
        end else begin
            op_a_d = op_a_q;
            op_b_d = op_b_q;
        end
    end

    // State registers; the reset indicator keeps tracking reset even while it is asserted.
    always_ff @(posedge CLK100MHZ) begin
        led_reset_q <= reset;
        if (reset) begin
            a_sync_q  <= {(SYNC_STAGES*8){1'b0}};
            b_sync_q  <= {(SYNC_STAGES*8){1'b0}};
            pb_sync_q <= {SYNC_STAGES{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            db_q      <= 1'b0;
            led_q     <= 16'h0000;
            op_a_q    <= 8'h00;
            op_b_q    <= 8'h00;
            pulse_q   <= 1'b0;
        end else begin
            a_sync_q  <= a_sync_d;
            b_sync_q  <= b_sync_d;
            pb_sync_q <= pb_sync_d;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            led_q     <= led_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            pulse_q   <= pulse_d;
        end
    end

    assign LED               = led_q;
    assign LED_reset         = led_reset_q;
    assign LED_pb            = db_q;
    assign multiplicador     = op_a_q;
    assign multiplicando     = op_b_q;
    assign pushbutton_salida = pulse_q;
endmodule

// File: tb/tb_lectura.sv
// Self-checking bench for lectura with a short debounce window and a cycle-level reference model.
module tb_lectura;
    localparam int SYNC = 2;
    localparam int DB   = 16;
    localparam int LAT  = SYNC + DB;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a, b;
    logic        pb;
    logic [15:0] LED;
    logic        LED_reset, LED_pb, pushbutton_salida;
    logic [7:0]  multiplicador, multiplicando;

    int n_cmp = 0;
    int n_err = 0;

    lectura #(.DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SYNC)) dut (
        .CLK100MHZ(clk), .reset(reset), .A(a), .B(b), .pb_entrada(pb),
        .LED(LED), .LED_reset(LED_reset), .LED_pb(LED_pb),
        .multiplicador(multiplicador), .multiplicando(multiplicando),
        .pushbutton_salida(pushbutton_salida)
    );

    always #5 clk = ~clk;

    // Reference model: inputs seen SYNC edges ago, debounced level flips after DB consecutive
    // disagreeing samples, press captures operands and raises the pulse for that cycle.
    logic [7:0]  a_h [SYNC];
    logic [7:0]  b_h [SYNC];
    logic        pb_h[SYNC];
    logic [15:0] m_led;
    logic        m_led_reset, m_db, m_pulse;
    logic [7:0]  m_ma, m_mb;
    int          m_run;

    always @(posedge clk) begin
        m_led_reset = reset;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) begin
                a_h[i] = 8'h00; b_h[i] = 8'h00; pb_h[i] = 1'b0;
            end
            m_led = 16'h0000; m_db = 1'b0; m_run = 0; m_pulse = 1'b0; m_ma = 8'h00; m_mb = 8'h00;
        end else begin
            m_led   = {b_h[SYNC-1], a_h[SYNC-1]};
            m_pulse = 1'b0;
            if (pb_h[SYNC-1] == m_db) m_run = 0;
            else begin
                m_run = m_run + 1;
                if (m_run == DB) begin
                    m_db  = ~m_db;
                    m_run = 0;
                    if (m_db) begin
                        m_pulse = 1'b1; m_ma = a_h[SYNC-1]; m_mb = b_h[SYNC-1];
                    end
                end
            end
            for (int i = SYNC - 1; i > 0; i--) begin
                a_h[i] = a_h[i-1]; b_h[i] = b_h[i-1]; pb_h[i] = pb_h[i-1];
            end
            a_h[0] = a; b_h[0] = b; pb_h[0] = pb;
        end
    end

    wire [34:0] dut_vec = {LED, LED_reset, LED_pb, multiplicador, multiplicando, pushbutton_salida};
    wire [34:0] mdl_vec = {m_led, m_led_reset, m_db, m_ma, m_mb, m_pulse};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_button();
        int t = 0;
        pb = 1'b0;
        while (LED_pb !== 1'b0 && t < 60) begin
            tick();
            t++;
        end
        repeat (SYNC + 2) tick();
        n_cmp++;
        if (LED_pb !== 1'b0) begin
            n_err++;
            $display("FAIL release_timeout: LED_pb=%b required 0", LED_pb);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; a = 8'h5A; b = 8'hC3; pb = 1'b0;
        repeat (3) begin
            tick();
            n_cmp++;
            if (dut_vec !== {16'h0000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
                n_err++;
                $display("FAIL reset_state: got %h required %h", dut_vec, {16'h0000, 1'b1, 18'h0});
            end
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL model_reset: dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (i == 2) begin
                n_cmp++;
                if (LED !== 16'h0000) begin
                    n_err++;
                    $display("FAIL reset_led_early: LED=%h required 0000", LED);
                end
            end
        end
        n_cmp++;
        if (LED !== 16'hC35A || LED_reset !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: LED=%h LED_reset=%b required c35a/0", LED, LED_reset);
        end
    endtask

    task automatic test_sweep();
        for (int v = 0; v <= 5; v++) begin
            a = 8'(v); b = 8'(v);
            tick();
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL model_sweep: dut=%h model=%h", dut_vec, mdl_vec);
            end
        end
        repeat (3) tick();
        n_cmp++;
        if (LED !== 16'h0505 || {multiplicador, multiplicando, pushbutton_salida} !== 17'h0) begin
            n_err++;
            $display("FAIL sweep_final: LED=%h ops=%h/%h pulse=%b required 0505 00/00 0",
                     LED, multiplicador, multiplicando, pushbutton_salida);
        end
        repeat (30) begin
            a = 8'($urandom); b = 8'($urandom);
            tick();
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL model_sweep_rand: dut=%h model=%h", dut_vec, mdl_vec);
            end
        end
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int plat = -1;
        release_button();
        a = 8'd5; b = 8'd3;
        repeat (4) tick();
        pb = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL model_press: dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (pushbutton_salida === 1'b1) begin
                pulses++;
                if (plat < 0) begin
                    plat = t;
                    n_cmp++;
                    if (multiplicador !== 8'd5 || multiplicando !== 8'd3 || LED_pb !== 1'b1) begin
                        n_err++;
                        $display("FAIL press_operands: got %h/%h pb=%b required 05/03 1",
                                 multiplicador, multiplicando, LED_pb);
                    end
                end
            end
        end
        n_cmp++;
        if (pulses != 1 || plat != LAT) begin
            n_err++;
            $display("FAIL press_pulse: pulses=%0d latency=%0d required 1/%0d", pulses, plat, LAT);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        int plat = -1;
        release_button();
        for (int i = 0; i < 40; i++) begin
            pb = ((i / 4) % 2 == 0);
            tick();
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL model_bounce: dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (pushbutton_salida === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_err++;
            $display("FAIL bounce_no_pulse: pulses=%0d required 0", pulses);
        end
        pb = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (pushbutton_salida === 1'b1) begin
                pulses++;
                if (plat < 0) plat = t;
            end
        end
        n_cmp++;
        if (pulses != 1 || plat != LAT) begin
            n_err++;
            $display("FAIL bounce_pulse: pulses=%0d latency=%0d required 1/%0d", pulses, plat, LAT);
        end
    endtask

    task automatic test_hold_retrigger();
        int pulses = 0;
        logic [7:0] cap_a = 8'h00;
        release_button();
        a = 8'd5; b = 8'd3;
        repeat (4) tick();
        pb = 1'b1;
        for (int t = 1; t <= 1000; t++) begin
            if (t == 500) a = 8'd9;
            tick();
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL model_hold: dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (pushbutton_salida === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || multiplicador !== 8'd5) begin
            n_err++;
            $display("FAIL hold_single: pulses=%0d op_a=%h required 1/05", pulses, multiplicador);
        end
        pb = 1'b0;
        pulses = 0;
        repeat (20) begin
            tick();
            if (pushbutton_salida === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || LED_pb !== 1'b0) begin
            n_err++;
            $display("FAIL release_no_pulse: pulses=%0d LED_pb=%b required 0/0", pulses, LED_pb);
        end
        pb = 1'b1;
        repeat (40) begin
            tick();
            if (pushbutton_salida === 1'b1) begin
                pulses++;
                cap_a = multiplicador;
            end
        end
        n_cmp++;
        if (pulses != 1 || cap_a !== 8'd9 || multiplicando !== 8'd3) begin
            n_err++;
            $display("FAIL retrigger: pulses=%0d op_a=%h op_b=%h required 1/09/03",
                     pulses, cap_a, multiplicando);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int plat = -1;
        release_button();
        pb = 1'b1;
        repeat (8) tick();
        reset = 1'b1;
        repeat (2) tick();
        n_cmp++;
        if (LED_pb !== 1'b0 || pushbutton_salida !== 1'b0 || LED_reset !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_state: pb=%b pulse=%b rst=%b required 0/0/1",
                     LED_pb, pushbutton_salida, LED_reset);
        end
        reset = 1'b0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_err++;
                $display("FAIL model_mid_reset: dut=%h model=%h", dut_vec, mdl_vec);
            end
            if (pushbutton_salida === 1'b1) begin
                pulses++;
                if (plat < 0) plat = t;
            end
        end
        n_cmp++;
        if (pulses != 1 || plat != LAT) begin
            n_err++;
            $display("FAIL mid_reset_pulse: pulses=%0d latency=%0d required 1/%0d", pulses, plat, LAT);
        end
    endtask

    task automatic test_random();
        int cyc = 0;
        while (cyc < 1500) begin
            int len = $urandom_range(1, 24);
            a  = 8'($urandom);
            b  = 8'($urandom);
            pb = 1'($urandom);
            for (int k = 0; k < len; k++) begin
                reset = ($urandom_range(0, 99) == 0);
                tick();
                cyc++;
                n_cmp++;
                if (dut_vec !== mdl_vec) begin
                    n_err++;
                    $display("FAIL model_random: dut=%h model=%h", dut_vec, mdl_vec);
                end
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; a = 8'h00; b = 8'h00; pb = 1'b0;
        test_reset();
        test_sweep();
        test_clean_press();
        test_bounce();
        test_hold_retrigger();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
